// File: rtl/sha1_pkg.sv
// Shared SHA-1 front-end definitions: block/word/digest geometry, the
// sequencer FSM states and the padding marker word.
package sha1_pkg;

  localparam int unsigned SHA1_BLK_W     = 512;
  localparam int unsigned SHA1_WORD_W    = 32;
  localparam int unsigned SHA1_DIG_W     = 160;
  localparam int unsigned SHA1_LEN_WORD  = 14;
  localparam int unsigned SHA1_BLK_WORDS = SHA1_BLK_W / SHA1_WORD_W;
  localparam int unsigned SHA1_IDX_W     = 4;

  localparam logic [SHA1_WORD_W-1:0] SHA1_PAD_WORD = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } sha1_state_e;

endpackage

// File: rtl/sha1_pad_word.sv
// Terminates a partial last word: keeps the valid leading bytes, places the
// 0x80 marker in the following byte and clears the rest.
//   word     : message word, big-endian (first byte in [31:24])
//   bytes    : valid bytes (1..3); 0 means a full word, passed through unchanged
//   padded_c : masked word with the marker inserted (combinational)
module sha1_pad_word
  import sha1_pkg::*;
(
  input  logic [SHA1_WORD_W-1:0] word,
  input  logic [1:0]             bytes,
  output logic [SHA1_WORD_W-1:0] padded_c
);

  always_comb begin
    padded_c = word;
    case (bytes)
      2'd1:    padded_c = {word[31:24], 24'h80_0000};
      2'd2:    padded_c = {word[31:16], 16'h8000};
      2'd3:    padded_c = {word[31:8],  8'h80};
      default: padded_c = word;
    endcase
  end

endmodule

// File: rtl/sha1_msg_sequencer.sv
// SHA-1 message front end: collects 32-bit words into 512-bit blocks, applies
// SHA-1 padding and the 64-bit bit length, hands blocks to the compression
// core one at a time and returns the final chaining value as the digest.
//   clk, reset              : clock, synchronous active-high reset
//   msg_start / in_empty    : begin a message (in_empty: zero-length message)
//   in_valid/in_ready/in_data/in_last/in_bytes : word stream input
//   core_start / core_cont  : issue pulse for first / chained block on core_msg
//   core_blk_done/core_hash : core completion and its chaining value
//   busy, done, digest_o    : status, digest-valid pulse, final hash
module sha1_msg_sequencer
  import sha1_pkg::*;
#(
  parameter int unsigned LEN_W     = 64,
  parameter bit          HOLD_HASH = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   msg_start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SHA1_WORD_W-1:0] in_data,
  input  logic                   in_last,
  input  logic [1:0]             in_bytes,
  input  logic                   in_empty,
  output logic                   core_start,
  output logic                   core_cont,
  output logic [SHA1_BLK_W-1:0]  core_msg,
  input  logic                   core_blk_done,
  input  logic [SHA1_DIG_W-1:0]  core_hash,
  output logic                   busy,
  output logic                   done,
  output logic [SHA1_DIG_W-1:0]  digest_o
);

  sha1_state_e state, state_d;
  logic in_ready_d, core_start_d, core_cont_d, busy_d, done_d;

  logic [SHA1_WORD_W-1:0] blk [SHA1_BLK_WORDS];
  logic [SHA1_IDX_W-1:0]  idx;
  logic [LEN_W-1:0]       bitcnt;
  logic                   first_blk;  // next issue is the first block of the message
  logic                   pad_done;   // 0x80 marker already written
  logic                   last_seen;  // all message words consumed
  logic                   final_blk;  // buffered block carries the length field

  logic                   accept;
  logic                   start_ok;
  logic                   last_full;
  logic [2:0]             byte_cnt;
  logic [5:0]             add_bits;
  logic                   pad_fits;
  logic [63:0]            msg_len;
  logic [SHA1_WORD_W-1:0] padded;

  assign accept    = in_valid & in_ready;
  assign start_ok  = msg_start & ((state == ST_IDLE) | (state == ST_DONE));
  assign last_full = (in_bytes == 2'd0);
  assign byte_cnt  = last_full ? 3'd4 : {1'b0, in_bytes};
  assign add_bits  = in_last ? {byte_cnt, 3'b000} : 6'd32;
  assign msg_len   = 64'(bitcnt);
  // Length fits if the marker lands before the length words (byte offset < 56).
  assign pad_fits  = pad_done ? (idx <= 4'(SHA1_LEN_WORD)) : (idx < 4'(SHA1_LEN_WORD));

  sha1_pad_word u_pad (
    .word     (in_data),
    .bytes    (in_bytes),
    .padded_c (padded)
  );

  // Block buffer presented to the core, word 0 in the top bits.
  for (genvar g = 0; g < int'(SHA1_BLK_WORDS); g++) begin : g_msg
    assign core_msg[SHA1_BLK_W-1-g*SHA1_WORD_W -: SHA1_WORD_W] = blk[g];
  end

  // State and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      core_start <= 1'b0;
      core_cont  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      in_ready   <= in_ready_d;
      core_start <= core_start_d;
      core_cont  <= core_cont_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next state and next control outputs.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (msg_start)              state_d = in_empty ? ST_PAD : ST_FILL;
        else if (state == ST_DONE)  state_d = ST_IDLE;
      end
      ST_FILL: begin
        if (accept) begin
          if (idx == 4'(SHA1_BLK_WORDS - 1)) state_d = ST_ISSUE;
          else if (in_last)                  state_d = ST_PAD;
        end
      end
      ST_PAD:   state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_blk_done) begin
          if (final_blk)      state_d = ST_DONE;
          else if (last_seen) state_d = ST_PAD;
          else                state_d = ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d   = (state_d == ST_FILL);
    core_start_d = (state == ST_ISSUE) & first_blk;
    core_cont_d  = (state == ST_ISSUE) & ~first_blk;
    busy_d       = (state_d != ST_IDLE) & (state_d != ST_DONE);
    done_d       = (state_d == ST_DONE);
  end

  // Block buffer, bit counter, padding bookkeeping and digest.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < int'(SHA1_BLK_WORDS); w++) blk[w] <= '0;
      idx       <= '0;
      bitcnt    <= '0;
      first_blk <= 1'b0;
      pad_done  <= 1'b0;
      last_seen <= 1'b0;
      final_blk <= 1'b0;
      digest_o  <= '0;
    end else begin
      if (start_ok) begin
        idx       <= '0;
        bitcnt    <= '0;
        first_blk <= 1'b1;
        pad_done  <= 1'b0;
        last_seen <= in_empty;
        final_blk <= 1'b0;
        digest_o  <= '0;
      end else if (state == ST_DONE && !HOLD_HASH) begin
        digest_o  <= '0;
      end
      case (state)
        ST_FILL: begin
          if (accept) begin
            blk[idx] <= (in_last && !last_full) ? padded : in_data;
            idx      <= idx + 4'd1;
            bitcnt   <= bitcnt + LEN_W'(add_bits);
            if (in_last) begin
              last_seen <= 1'b1;
              pad_done  <= ~last_full;
            end
          end
        end
        ST_PAD: begin
          // Words from idx onward: marker (if still owed) then zeros.
          for (int w = 0; w < int'(SHA1_BLK_WORDS); w++) begin
            if (4'(w) >= idx)
              blk[w] <= (!pad_done && 4'(w) == idx) ? SHA1_PAD_WORD : '0;
          end
          if (pad_fits) begin
            blk[SHA1_LEN_WORD]     <= msg_len[63:32];
            blk[SHA1_LEN_WORD + 1] <= msg_len[31:0];
            final_blk              <= 1'b1;
          end else begin
            final_blk              <= 1'b0;
          end
          pad_done <= 1'b1;
          idx      <= '0;
        end
        ST_ISSUE: first_blk <= 1'b0;
        ST_WAIT: begin
          if (core_blk_done && final_blk) digest_o <= core_hash;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_msg_sequencer.sv
module tb_sha1_msg_sequencer;

  typedef logic [7:0] byte_q[$];

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         msg_start = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [1:0]   in_bytes = '0;
  logic         in_empty = 1'b0;
  logic         core_start, core_cont;
  logic [511:0] core_msg;
  logic         stub_done = 1'b0;
  logic         spur_done = 1'b0;
  logic [159:0] h_state = '0;
  logic         busy, done;
  logic [159:0] digest_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] cyc = '0;
  int n_done = 0;

  localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

  sha1_msg_sequencer #(.LEN_W(64), .HOLD_HASH(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .msg_start     (msg_start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_bytes      (in_bytes),
    .in_empty      (in_empty),
    .core_start    (core_start),
    .core_cont     (core_cont),
    .core_msg      (core_msg),
    .core_blk_done (stub_done | spur_done),
    .core_hash     (h_state),
    .busy          (busy),
    .done          (done),
    .digest_o      (digest_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done === 1'b1) n_done <= n_done + 1;

  // Reference SHA-1 compression function.
  function automatic logic [159:0] sha1_compress(input logic [159:0] hin, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t, x;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {x[30:0], x[31]};
    end
    a = hin[159:128]; b = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
  endfunction

  // Scoreboard queues
  logic [511:0] exp_blk[$];
  bit           exp_first[$];
  logic [159:0] exp_dig[$];

  // Stub core: fixed 80-cycle latency, real SHA-1 chaining.
  int           pend_cnt = 0;
  int           n_start = 0, n_cont = 0;
  logic [511:0] held_msg = '0, last_blk = '0, eb;
  bit           ef;
  bit           rdy_viol = 0, msg_unstable = 0;
  logic [31:0]  last_done_cyc = '0;

  always @(negedge clk) begin
    stub_done = 1'b0;
    if (pend_cnt > 0) begin
      if (in_ready === 1'b1) rdy_viol = 1;
      if (core_msg !== held_msg) msg_unstable = 1;
      pend_cnt--;
      if (pend_cnt == 0) begin
        stub_done = 1'b1;
        last_done_cyc = cyc;
      end
    end
    if (core_start === 1'b1 || core_cont === 1'b1) begin
      if (core_start === 1'b1) begin n_start++; h_state = sha1_compress(IV, core_msg); end
      else                     begin n_cont++;  h_state = sha1_compress(h_state, core_msg); end
      checks++;
      if (exp_blk.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: start=%b cont=%b blk=%h", core_start, core_cont, core_msg);
      end else begin
        eb = exp_blk.pop_front();
        ef = exp_first.pop_front();
        if (core_msg !== eb || core_start !== ef || core_cont !== !ef) begin
          errors++;
          $display("FAIL issue_block: start=%b cont=%b got %h want first=%b %h",
                   core_start, core_cont, core_msg, ef, eb);
        end
      end
      held_msg = core_msg;
      last_blk = core_msg;
      pend_cnt = 80;
    end
  end

  function automatic byte_q make_msg(input int n, input int seed);
    byte_q q;
    for (int i = 0; i < n; i++) q.push_back(8'(i * 7 + seed));
    return q;
  endfunction

  // Reference padding: msg, 0x80, zeros to 56 mod 64, 64-bit length.
  task automatic push_expected(input byte_q m);
    byte_q p;
    logic [63:0] len;
    logic [511:0] blk;
    logic [159:0] h;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    len = 64'(m.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(8'(len >> (8 * k)));
    h = IV;
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b + j];
      exp_blk.push_back(blk);
      exp_first.push_back(b == 0);
      h = sha1_compress(h, blk);
    end
    exp_dig.push_back(h);
  endtask

  task automatic drive_msg(input byte_q m, input bit gaps, input bit spur);
    int n, nw, waited;
    logic [31:0] wd;
    n = m.size();
    nw = (n + 3) / 4;
    @(negedge clk);
    msg_start = 1'b1; in_empty = (n == 0);
    @(negedge clk);
    msg_start = 1'b0; in_empty = 1'b0;
    for (int i = 0; i < nw; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_last = 1'b1; in_data = $urandom;
        @(negedge clk);
      end
      if (spur && i == 2) begin
        in_valid = 1'b0; spur_done = 1'b1; msg_start = 1'b1;
        @(negedge clk);
        spur_done = 1'b0; msg_start = 1'b0;
      end
      for (int j = 0; j < 4; j++) wd[31-8*j -: 8] = (4*i + j < n) ? m[4*i + j] : 8'ha5;
      in_valid = 1'b1;
      in_data  = wd;
      in_last  = (i == nw - 1);
      in_bytes = (i == nw - 1) ? 2'(n % 4) : 2'($urandom);
      waited = 0;
      while (in_ready !== 1'b1 && waited < 400) begin @(negedge clk); waited++; end
      if (waited >= 400) begin
        checks++; errors++;
        $display("FAIL handshake_timeout: word %0d in_ready=%b want 1", i, in_ready);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Drive one message and check digest, done timing, hold and completeness.
  task automatic run_msg(input string name, input byte_q m, input bit gaps, input bit spur,
                         output logic [159:0] dig);
    int k;
    logic [159:0] expd;
    push_expected(m);
    drive_msg(m, gaps, spur);
    k = 0;
    while (done !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    expd = exp_dig.pop_front();
    dig = digest_o;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b want 1", name, done);
      exp_blk.delete(); exp_first.delete();
      return;
    end
    checks++;
    if (digest_o !== expd) begin
      errors++; $display("FAIL %s_digest: got %h want %h", name, digest_o, expd);
    end
    checks++;
    if (cyc !== last_done_cyc + 1) begin
      errors++; $display("FAIL %s_done_latency: got cycle %0d want %0d", name, cyc, last_done_cyc + 1);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || digest_o !== expd) begin
      errors++;
      $display("FAIL %s_after_done: done=%b busy=%b digest=%h want 0 0 %h", name, done, busy, digest_o, expd);
    end
    checks++;
    if (exp_blk.size() != 0 || rdy_viol || msg_unstable) begin
      errors++;
      $display("FAIL %s_blocks: pending=%0d rdy_viol=%0d unstable=%0d want 0 0 0",
               name, exp_blk.size(), rdy_viol, msg_unstable);
    end
    exp_blk.delete(); exp_first.delete();
    rdy_viol = 0; msg_unstable = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, core_start, core_cont, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rdy/start/cont/busy/done=%b want 00000",
               {in_ready, core_start, core_cont, busy, done});
    end
    checks++;
    if (digest_o !== '0 || core_msg !== '0) begin
      errors++; $display("FAIL reset_data: digest=%h msg=%h want 0", digest_o, core_msg);
    end
  endtask

  task automatic test_abc();
    byte_q m;
    logic [159:0] dig;
    int s0, c0;
    m = {8'h61, 8'h62, 8'h63};
    s0 = n_start; c0 = n_cont;
    run_msg("abc", m, 0, 0, dig);
    checks++;
    if (dig !== 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d) begin
      errors++; $display("FAIL abc_known_digest: got %h", dig);
    end
    checks++;
    if (n_start - s0 != 1 || n_cont - c0 != 0 || last_blk[511:480] !== 32'h61626380
        || last_blk[479:0] !== 480'h18) begin
      errors++;
      $display("FAIL abc_block: starts=%0d conts=%0d blk=%h want 1 0 61626380..18",
               n_start - s0, n_cont - c0, last_blk);
    end
  endtask

  task automatic test_empty();
    byte_q m;
    logic [159:0] dig;
    logic [511:0] want;
    m = {};
    want = '0; want[511:480] = 32'h8000_0000;
    run_msg("empty", m, 0, 0, dig);
    checks++;
    if (dig !== 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709 || last_blk !== want) begin
      errors++; $display("FAIL empty_known: digest=%h blk=%h", dig, last_blk);
    end
  endtask

  task automatic test_len_boundaries();
    logic [159:0] dig;
    int s0, c0;
    s0 = n_start; c0 = n_cont;
    run_msg("len55", make_msg(55, 1), 0, 0, dig);
    checks++;
    if (n_start - s0 != 1 || n_cont - c0 != 0 || last_blk[71:64] !== 8'h80 || last_blk[63:0] !== 64'h1b8) begin
      errors++;
      $display("FAIL len55_block: starts=%0d conts=%0d w13=%h len=%h want 1 0 ..80 1b8",
               n_start - s0, n_cont - c0, last_blk[95:64], last_blk[63:0]);
    end
    s0 = n_start; c0 = n_cont;
    run_msg("len56", make_msg(56, 2), 0, 0, dig);
    checks++;
    if (n_start - s0 != 1 || n_cont - c0 != 1 || last_blk[511:64] !== '0 || last_blk[63:0] !== 64'h1c0) begin
      errors++;
      $display("FAIL len56_block: starts=%0d conts=%0d blk=%h want 1 1 zeros+1c0",
               n_start - s0, n_cont - c0, last_blk);
    end
  endtask

  task automatic test_len64_gaps();
    logic [159:0] dig;
    int c0;
    c0 = n_cont;
    run_msg("len64", make_msg(64, 3), 1, 0, dig);
    checks++;
    if (n_cont - c0 != 1 || last_blk[511:480] !== 32'h8000_0000 || last_blk[479:64] !== '0
        || last_blk[63:0] !== 64'h200) begin
      errors++;
      $display("FAIL len64_block: conts=%0d blk=%h want 1 80000000..200", n_cont - c0, last_blk);
    end
  endtask

  task automatic test_reset_abort();
    byte_q m;
    logic [159:0] dig;
    int k, s0, c0, d0;
    m = make_msg(64, 4);
    push_expected(m);
    drive_msg(m, 0, 0);
    k = 0;
    while (pend_cnt == 0 && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (pend_cnt == 0) begin errors++; $display("FAIL abort_issue: first block pending=0 want >0"); end
    repeat (5) @(negedge clk);
    reset = 1'b1; msg_start = 1'b1;
    @(negedge clk);
    reset = 1'b0; msg_start = 1'b0;
    checks++;
    if ({in_ready, core_start, core_cont, busy, done} !== 5'b0 || digest_o !== '0 || core_msg !== '0) begin
      errors++;
      $display("FAIL abort_reset_vals: ctrl=%b digest=%h msg=%h want zeros",
               {in_ready, core_start, core_cont, busy, done}, digest_o, core_msg);
    end
    exp_blk.delete(); exp_first.delete(); exp_dig.delete();
    s0 = n_start; c0 = n_cont; d0 = n_done;
    k = 0;
    while (pend_cnt != 0 && k < 200) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || n_done != d0 || n_start != s0 || n_cont != c0) begin
      errors++;
      $display("FAIL abort_late_done: busy=%b dones=%0d issues=%0d want 0 0 0",
               busy, n_done - d0, n_start - s0 + n_cont - c0);
    end
    rdy_viol = 0; msg_unstable = 0;
    run_msg("abort_abc", {8'h61, 8'h62, 8'h63}, 0, 0, dig);
    checks++;
    if (dig !== 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d) begin
      errors++; $display("FAIL abort_abc_known: got %h", dig);
    end
  endtask

  task automatic test_spurious();
    logic [159:0] dig;
    int s0, c0, d0;
    s0 = n_start; c0 = n_cont; d0 = n_done;
    run_msg("spur", make_msg(20, 5), 0, 1, dig);
    checks++;
    if (n_start - s0 != 1 || n_cont - c0 != 0 || n_done - d0 != 1) begin
      errors++;
      $display("FAIL spur_pulses: starts=%0d conts=%0d dones=%0d want 1 0 1",
               n_start - s0, n_cont - c0, n_done - d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [159:0] dig;
    int c0;
    c0 = n_cont;
    run_msg("b2b_120", make_msg(120, 6), 1, 0, dig);
    checks++;
    if (n_cont - c0 != 2) begin
      errors++; $display("FAIL b2b_chain: conts=%0d want 2", n_cont - c0);
    end
    run_msg("b2b_4", make_msg(4, 7), 0, 0, dig);
    run_msg("b2b_7", make_msg(7, 8), 1, 0, dig);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_len_boundaries();
    test_len64_gaps();
    test_spurious();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
